// File: rtl/msg_buf.sv
// rtl/msg_buf.sv - word capture buffer with oldest-first replay on a valid/ready stream
module msg_buf #(
   parameter int DW    = 8,
   parameter int DEPTH = 16,
   parameter int WRAP  = 0
) (
   input  logic                       clk,
   input  logic                       rst_b,
   input  logic                       wr,
   input  logic [DW-1:0]              dat,
   input  logic                       clr,
   input  logic                       disp,
   output logic                       out_vld,
   output logic [DW-1:0]              out_dat,
   output logic                       out_last,
   input  logic                       out_rdy,
   output logic                       busy,
   output logic [$clog2(DEPTH):0]     cnt,
   output logic                       full,
   output logic                       ovf
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

   typedef enum logic {IDLE, DUMP} state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wptr, base, rptr;
   logic [CW-1:0] remaining;
   logic          accept, wr_store, wr_lost, dump_start;

   assign full       = (cnt == CNT_MAX);
   assign accept     = (state == DUMP) && out_rdy;
   assign wr_store   = (state == IDLE) && !clr && wr && (!full || (WRAP != 0));
   // Any write that does not land cleanly (dropped, overwriting, or during a dump) is an overflow
   assign wr_lost    = !clr && wr && ((state == DUMP) || full);
   assign dump_start = (state == IDLE) && !clr && disp && !wr && (cnt != '0);

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (dump_start) state_nxt = DUMP;
         DUMP: if (clr || (accept && remaining == CW'(1))) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      out_vld  = (state == DUMP);
      busy     = (state == DUMP);
      out_last = (state == DUMP) && (remaining == CW'(1));
      out_dat  = (state == DUMP) ? mem[rptr] : '0;
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         wptr      <= '0;
         base      <= '0;
         rptr      <= '0;
         remaining <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
      end else if (clr) begin
         wptr <= '0;
         base <= '0;
         cnt  <= '0;
         ovf  <= 1'b0;
      end else begin
         if (wr_store) begin
            wptr <= wptr + AW'(1);
            if (full) base <= base + AW'(1);
            else      cnt  <= cnt + CW'(1);
         end
         if (wr_lost) ovf <= 1'b1;
         if (dump_start) begin
            rptr      <= base;
            remaining <= cnt;
         end else if (accept) begin
            rptr      <= rptr + AW'(1);
            remaining <= remaining - CW'(1);
         end
      end
   end

   // Storage is left unreset; only entries below cnt are ever replayed
   always_ff @(posedge clk) begin
      if (wr_store) mem[wptr] <= dat;
   end
endmodule

// File: tb/tb_msg_buf.sv
// tb/tb_msg_buf.sv - randomized and directed bench for msg_buf, drop and wrap instances side by side
module tb_msg_buf;
   logic       clk, rst_b, wr, clr, disp, out_rdy;
   logic [7:0] dat;
   logic       vld0, last0, busy0, full0, ovf0;
   logic       vld1, last1, busy1, full1, ovf1;
   logic [7:0] dat0, dat1;
   logic [4:0] cnt0, cnt1;

   int checks = 0;
   int errors = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];
   bit         m_ovf0, m_ovf1;
   logic [7:0] hello [11] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
                              8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64};

   msg_buf #(.DW(8), .DEPTH(16), .WRAP(0)) u0 (
      .clk(clk), .rst_b(rst_b), .wr(wr), .dat(dat), .clr(clr), .disp(disp),
      .out_vld(vld0), .out_dat(dat0), .out_last(last0), .out_rdy(out_rdy),
      .busy(busy0), .cnt(cnt0), .full(full0), .ovf(ovf0));

   msg_buf #(.DW(8), .DEPTH(16), .WRAP(1)) u1 (
      .clk(clk), .rst_b(rst_b), .wr(wr), .dat(dat), .clr(clr), .disp(disp),
      .out_vld(vld1), .out_dat(dat1), .out_last(last1), .out_rdy(out_rdy),
      .busy(busy1), .cnt(cnt1), .full(full1), .ovf(ovf1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      q0.delete();
      q1.delete();
      m_ovf0 = 1'b0;
      m_ovf1 = 1'b0;
   endtask

   task automatic model_write(input logic [7:0] b);
      if (q0.size() < 16) q0.push_back(b);
      else m_ovf0 = 1'b1;
      if (q1.size() < 16) q1.push_back(b);
      else begin
         void'(q1.pop_front());
         q1.push_back(b);
         m_ovf1 = 1'b1;
      end
   endtask

   task automatic status_chk();
      chk("cnt0", cnt0, q0.size());
      chk("full0", full0, q0.size() == 16);
      chk("ovf0", ovf0, m_ovf0);
      chk("cnt1", cnt1, q1.size());
      chk("full1", full1, q1.size() == 16);
      chk("ovf1", ovf1, m_ovf1);
   endtask

   task automatic do_write(input logic [7:0] b);
      wr  = 1'b1;
      dat = b;
      @(negedge clk);
      wr  = 1'b0;
      model_write(b);
   endtask

   task automatic clr_pulse();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      model_clear();
   endtask

   // mode: 0 always ready, 1 ready pattern 1,0,0,1, 2 random; inj_kind: 0 write, 1 clear, 2 reset
   task automatic run_dump(input int mode, input int inj_beat, input int inj_kind);
      int n, idx, cyc;
      bit stop, injected;
      n = q0.size();
      disp = 1'b1;
      chk("vld_on_disp", vld0 | vld1, 0);
      @(negedge clk);
      disp = 1'b0;
      if (n == 0) begin
         repeat (5) begin
            chk("empty_vld", vld0 | vld1, 0);
            chk("empty_busy", busy0 | busy1, 0);
            @(negedge clk);
         end
         return;
      end
      idx = 0; cyc = 0; stop = 0; injected = 0;
      while (!stop && idx < n && cyc < 400) begin
         out_rdy = (mode == 0) ? 1'b1 :
                   (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'($urandom_range(0, 1));
         chk("vld0", vld0, 1);
         chk("vld1", vld1, 1);
         chk("busy0", busy0, 1);
         chk("dat0", dat0, q0[idx]);
         chk("dat1", dat1, q1[idx]);
         chk("last0", last0, idx == n - 1);
         chk("last1", last1, idx == n - 1);
         if (!injected && idx == inj_beat && inj_kind == 2) begin
            #2 rst_b = 1'b0;
            #1;
            chk("rst_mid_dump0", {vld0, dat0, last0, busy0, cnt0, full0, ovf0}, 0);
            chk("rst_mid_dump1", {vld1, dat1, last1, busy1, cnt1, full1, ovf1}, 0);
            model_clear();
            @(negedge clk);
            rst_b = 1'b1;
            stop  = 1;
         end else begin
            if (!injected && idx == inj_beat && inj_kind == 0) begin
               wr  = 1'b1;
               dat = 8'($urandom);
               m_ovf0 = 1'b1;
               m_ovf1 = 1'b1;
               injected = 1;
            end
            if (!injected && idx == inj_beat && inj_kind == 1) begin
               clr = 1'b1;
               injected = 1;
            end
            @(negedge clk);
            wr = 1'b0;
            if (clr) begin
               clr = 1'b0;
               chk("clr_vld", vld0 | vld1, 0);
               chk("clr_cnt", cnt0, 0);
               chk("clr_ovf", ovf0, 0);
               model_clear();
               stop = 1;
            end else if (out_rdy) begin
               idx++;
            end
         end
         cyc++;
      end
      if (!stop) begin
         chk("dump_len", idx, n);
         chk("end_vld", vld0 | vld1, 0);
         chk("end_busy", busy0 | busy1, 0);
      end
   endtask

   initial begin
      rst_b = 1'b0; wr = 1'b0; clr = 1'b0; disp = 1'b0; out_rdy = 1'b0; dat = '0;
      model_clear();
      repeat (3) @(negedge clk);
      chk("reset0", {vld0, dat0, last0, busy0, cnt0, full0, ovf0}, 0);
      chk("reset1", {vld1, dat1, last1, busy1, cnt1, full1, ovf1}, 0);
      rst_b = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 11; i++) do_write(hello[i]);
      status_chk();
      run_dump(0, -1, 0);
      run_dump(1, -1, 0);
      run_dump(1, -1, 0);
      status_chk();

      clr_pulse();
      for (int i = 0; i < 20; i++) do_write(8'(i));
      status_chk();
      run_dump(0, -1, 0);

      clr_pulse();
      for (int i = 0; i < 8; i++) do_write(8'($urandom));
      run_dump(2, 3, 0);
      status_chk();
      run_dump(0, 3, 1);
      status_chk();

      run_dump(0, -1, 0);
      status_chk();

      for (int i = 0; i < 8; i++) do_write(8'($urandom));
      run_dump(0, 2, 2);
      @(negedge clk);
      status_chk();
      do_write(8'h41);
      do_write(8'h42);
      run_dump(0, -1, 0);

      wr = 1'b1; dat = 8'h55; disp = 1'b1;
      @(negedge clk);
      wr = 1'b0; disp = 1'b0;
      model_write(8'h55);
      chk("wr_disp_vld", vld0 | vld1, 0);
      chk("wr_disp_busy", busy0 | busy1, 0);
      status_chk();

      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 5))
            0, 1: begin
               int len;
               len = $urandom_range(1, 20);
               for (int k = 0; k < len; k++) do_write(8'($urandom));
            end
            2, 3: run_dump($urandom_range(0, 2), -1, 0);
            4:    clr_pulse();
            default: run_dump($urandom_range(0, 2), $urandom_range(0, 10), 0);
         endcase
         status_chk();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/msg_buf.md
Name: msg_buf

Overview:
- Parametrised successor to the single-byte store/display DUT.
- Captures a stream of DW-bit words (e.g. ASCII string bytes) into an internal buffer of DEPTH entries.
- On a `disp` trigger, replays the stored words oldest-first on a valid/ready output stream, for a checker or console model downstream.
- Adds circular-overwrite mode, occupancy/full/overflow status, clear, and backpressure.

Parameters:
- DW, 8, data word width in bits.
- DEPTH, 16, number of buffer entries (>=2, power of two).
- WRAP, 0: 0 = drop writes when full; 1 = circular, overwrite oldest entry.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_b  in  1  asynchronous active-low reset.
- wr  in  1  write strobe; `dat` captured on the edge where wr=1.
- dat  in  DW  write data.
- clr  in  1  synchronous clear of buffer state.
- disp  in  1  start dump (single-cycle pulse; level also accepted, edge not required).
- out_vld  out  1  output word valid.
- out_dat  out  DW  output word.
- out_last  out  1  marks final word of a dump, qualified by out_vld.
- out_rdy  in  1  downstream accepts word when out_vld&&out_rdy.
- busy  out  1  dump in progress.
- cnt  out  $clog2(DEPTH)+1  stored entry count, 0..DEPTH.
- full  out  1  cnt==DEPTH.
- ovf  out  1  sticky: a write was dropped (WRAP=0), overwrote data (WRAP=1), or arrived during a dump.

Behaviour:
- Reset (rst_b=0, async): out_vld=0, out_dat=0, out_last=0, busy=0, cnt=0, full=0, ovf=0, pointers=0, state=IDLE.
  - Memory array is not reset.
  - Reset mid-dump aborts the dump immediately.
- Pointers: wptr and base (oldest entry), each $clog2(DEPTH) bits, wrapping modulo DEPTH.
- FSM states: IDLE, DUMP.
- IDLE, write handling:
  - wr=1 and not full: mem[wptr]<=dat, wptr++, cnt++.
  - wr=1 and full, WRAP=0: write dropped, ovf<=1, cnt unchanged.
  - wr=1 and full, WRAP=1: mem[wptr]<=dat, wptr++, base++, cnt stays DEPTH, ovf<=1.
- IDLE, dump start:
  - disp=1, cnt>0, wr=0: go to DUMP; rptr<=base, remaining<=cnt, busy<=1.
  - disp=1 with cnt==0: ignored, no output beat.
  - disp=1 and wr=1 in the same cycle: the write is performed and disp is ignored.
- DUMP, output timing:
  - First out_vld rises one cycle after disp is sampled.
  - Each beat: out_dat=mem[rptr], out_last=(remaining==1).
- DUMP, handshake:
  - While out_vld&&!out_rdy, out_dat and out_last hold stable.
  - On accept, rptr++ (mod DEPTH), remaining--, and the next word is presented the following cycle (one word per cycle at full throughput).
- DUMP, completion:
  - On acceptance of the last word: out_vld<=0, out_last<=0, busy<=0, return to IDLE.
  - Contents, cnt and pointers are retained; the dump is non-destructive and repeatable.
- DUMP, other inputs:
  - wr=1: write dropped, ovf<=1.
  - disp=1: ignored.
- clr=1 (any state): next cycle wptr=base=0, cnt=0, full=0, ovf=0, out_vld=0, out_last=0, busy=0, state=IDLE.
  - clr takes priority over wr and disp in the same cycle.
- full is combinational from cnt, or registered consistently with it (same-cycle agreement required).
- out_vld never asserts outside DUMP.

Test Plan:
- DEPTH=16, WRAP=0: write "Hello World" (11 bytes), pulse disp, out_rdy=1.
  - Required: cnt=11; 11 consecutive beats 0x48,0x65,0x6C,0x6C,0x6F,0x20,0x57,0x6F,0x72,0x6C,0x64.
  - out_last only on 0x64; first out_vld one cycle after disp; busy low after the last beat.
- Same data with out_rdy toggling 1,0,0,1 repeatedly.
  - Required: identical sequence, no duplicated or skipped words, out_dat stable while stalled.
  - A second disp replays the same 11 bytes.
- WRAP=0: write bytes 0x00..0x13 (20 words), then dump.
  - Required: cnt=16, full=1, ovf=1; dump outputs 0x00..0x0F, last on 0x0F.
- WRAP=1: same 20 writes, then dump.
  - Required: cnt=16, ovf=1; dump outputs 0x04..0x13.
- Write 8 words, disp; after 3 accepted beats assert wr.
  - Required: wr ignored, ovf=1, dump completes all 8 beats.
  - Repeat, but assert clr after 3 beats: required out_vld=0 next cycle, cnt=0, ovf=0.
- Empty-buffer and reset cases:
  - disp with cnt=0 -> no out_vld for 5 cycles, busy=0.
  - rst_b low mid-dump -> all outputs at reset values immediately.
  - Writing "AB" after reset and dumping -> 0x41,0x42.
